// File: rtl/sim_uart_bridge.sv
// sim_uart_bridge
//   HDL-side UART cosimulation endpoint. Serialises host bytes onto the DUT's
//   uart_rx line and deserialises the DUT's uart_tx line back to the host,
//   with framing, overrun and optional even-parity checking. It also exposes
//   receiver timing for cosim observation.
//
//   Optional feature macro: SIM_UART_BRIDGE_PARITY_EN
//     defined   -> even parity bit after the data bits (TX inserts, RX checks)
//     undefined -> no parity bit, rx_parity_err tied low
//
// Ports
//   clock, reset_n        single clock, asynchronous active-low reset
//   tx_data/valid/ready   host -> DUT byte handshake (ready == TX idle)
//   rx_data/valid/ready   DUT -> host byte handshake
//   rx_frame_err          1-cycle pulse, stop bit sampled low
//   rx_parity_err         1-cycle pulse, parity mismatch
//   rx_overrun            1-cycle pulse, byte dropped while rx_valid set
//   uart_rx               serial line into the DUT, idles high
//   uart_tx               serial line out of the DUT (synchronised here)
//   uart_sampling         high on each receiver sample cycle
//   uart_ticks_counter    receiver tick counter, zero-extended
//   uart_ticks_per_baud   constant TICKS_PER_BAUD
module sim_uart_bridge #(
  parameter int unsigned TICKS_PER_BAUD = 4,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned STOP_BITS      = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun,
  output logic                 uart_rx,
  input  logic                 uart_tx,
  output logic                 uart_sampling,
  output logic [7:0]           uart_ticks_counter,
  output logic [31:0]          uart_ticks_per_baud
);

  localparam int unsigned TW = $clog2(TICKS_PER_BAUD);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BAUD - 1);
  // The IDLE cycle that detects the falling edge is already the first cycle
  // of the start bit, so the mid-bit point is one count earlier in START.
  // This keeps the sample inside the bit even at TICKS_PER_BAUD = 2.
  localparam logic [TW-1:0] TICK_MID  = TW'(TICKS_PER_BAUD / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  assign uart_ticks_per_baud = 32'(TICKS_PER_BAUD);

  // ---------------------------------------------------------------- TX side
  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef SIM_UART_BRIDGE_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  tx_state_t            tx_state;
  logic [TW-1:0]        tx_tick;
  logic [BW-1:0]        tx_bit;   // data bit index, reused as stop bit index
  logic [DATA_BITS-1:0] tx_sh;
`ifdef SIM_UART_BRIDGE_PARITY_EN
  logic                 tx_par;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= TX_IDLE;
      tx_tick  <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      uart_rx  <= 1'b1;
      tx_ready <= 1'b1;
`ifdef SIM_UART_BRIDGE_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_valid) begin
            tx_sh    <= tx_data;
`ifdef SIM_UART_BRIDGE_PARITY_EN
            tx_par   <= ^tx_data;
`endif
            tx_tick  <= '0;
            uart_rx  <= 1'b0;
            tx_ready <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_tick == TICK_LAST) begin
            tx_tick  <= '0;
            tx_bit   <= '0;
            uart_rx  <= tx_sh[0];
            tx_sh    <= tx_sh >> 1;
            tx_state <= TX_DATA;
          end else begin
            tx_tick <= tx_tick + TW'(1);
          end
        end
        TX_DATA: begin
          if (tx_tick == TICK_LAST) begin
            tx_tick <= '0;
            if (tx_bit == BIT_LAST) begin
`ifdef SIM_UART_BRIDGE_PARITY_EN
              uart_rx  <= tx_par;
              tx_state <= TX_PARITY;
`else
              uart_rx  <= 1'b1;
              tx_bit   <= '0;
              tx_state <= TX_STOP;
`endif
            end else begin
              tx_bit  <= tx_bit + BW'(1);
              uart_rx <= tx_sh[0];
              tx_sh   <= tx_sh >> 1;
            end
          end else begin
            tx_tick <= tx_tick + TW'(1);
          end
        end
`ifdef SIM_UART_BRIDGE_PARITY_EN
        TX_PARITY: begin
          if (tx_tick == TICK_LAST) begin
            tx_tick  <= '0;
            tx_bit   <= '0;
            uart_rx  <= 1'b1;
            tx_state <= TX_STOP;
          end else begin
            tx_tick <= tx_tick + TW'(1);
          end
        end
`endif
        TX_STOP: begin
          if (tx_tick == TICK_LAST) begin
            tx_tick <= '0;
            if (tx_bit == STOP_LAST) begin
              tx_ready <= 1'b1;
              tx_state <= TX_IDLE;
            end else begin
              tx_bit <= tx_bit + BW'(1);
            end
          end else begin
            tx_tick <= tx_tick + TW'(1);
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX side
  logic [1:0] rx_sync;
  logic       rxs;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rx_sync <= '1;
    else          rx_sync <= {rx_sync[0], uart_tx};
  end
  assign rxs = rx_sync[1];

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef SIM_UART_BRIDGE_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  rx_state_t            rx_state;
  logic [TW-1:0]        rx_tick;
  logic [BW-1:0]        rx_bit;
  logic [DATA_BITS-1:0] rx_sh;
`ifdef SIM_UART_BRIDGE_PARITY_EN
  logic                 rx_par_bad;
`else
  assign rx_parity_err = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_state     <= RX_IDLE;
      rx_tick      <= '0;
      rx_bit       <= '0;
      rx_sh        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
`ifdef SIM_UART_BRIDGE_PARITY_EN
      rx_parity_err <= 1'b0;
      rx_par_bad    <= 1'b0;
`endif
    end else begin
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
`ifdef SIM_UART_BRIDGE_PARITY_EN
      rx_parity_err <= 1'b0;
`endif
      // A load later in this block overrides the consume.
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      case (rx_state)
        RX_IDLE: begin
          rx_tick <= '0;
          if (!rxs) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_tick == TICK_MID) begin
            rx_tick <= '0;
            if (rxs) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_bit   <= '0;
              rx_state <= RX_DATA;
            end
          end else begin
            rx_tick <= rx_tick + TW'(1);
          end
        end
        RX_DATA: begin
          if (rx_tick == TICK_LAST) begin
            rx_tick <= '0;
            rx_sh   <= {rxs, rx_sh[DATA_BITS-1:1]};
            if (rx_bit == BIT_LAST) begin
`ifdef SIM_UART_BRIDGE_PARITY_EN
              rx_state <= RX_PARITY;
`else
              rx_state <= RX_STOP;
`endif
            end else begin
              rx_bit <= rx_bit + BW'(1);
            end
          end else begin
            rx_tick <= rx_tick + TW'(1);
          end
        end
`ifdef SIM_UART_BRIDGE_PARITY_EN
        RX_PARITY: begin
          if (rx_tick == TICK_LAST) begin
            rx_tick    <= '0;
            rx_par_bad <= rxs ^ (^rx_sh);
            rx_state   <= RX_STOP;
          end else begin
            rx_tick <= rx_tick + TW'(1);
          end
        end
`endif
        RX_STOP: begin
          if (rx_tick == TICK_LAST) begin
            rx_tick <= '0;
`ifdef SIM_UART_BRIDGE_PARITY_EN
            if (rx_par_bad) rx_parity_err <= 1'b1;
`endif
            if (!rxs) begin
              rx_frame_err <= 1'b1;
              rx_state     <= RX_BREAK;
            end else begin
              rx_state <= RX_IDLE;
`ifdef SIM_UART_BRIDGE_PARITY_EN
              if (!rx_par_bad)
`endif
              begin
                if (rx_valid && !rx_ready) begin
                  rx_overrun <= 1'b1;
                end else begin
                  rx_data  <= rx_sh;
                  rx_valid <= 1'b1;
                end
              end
            end
          end else begin
            rx_tick <= rx_tick + TW'(1);
          end
        end
        RX_BREAK: begin
          if (rxs) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_comb begin
    uart_sampling = 1'b0;
    case (rx_state)
      RX_START:  uart_sampling = (rx_tick == TICK_MID);
      RX_DATA:   uart_sampling = (rx_tick == TICK_LAST);
`ifdef SIM_UART_BRIDGE_PARITY_EN
      RX_PARITY: uart_sampling = (rx_tick == TICK_LAST);
`endif
      RX_STOP:   uart_sampling = (rx_tick == TICK_LAST);
      default:   uart_sampling = 1'b0;
    endcase
  end

  assign uart_ticks_counter = 8'(rx_tick);

endmodule
